// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 memory access unit:
// device register addresses, the access FSM state type and the MCR reset value.
package lc3_mem_pkg;

    localparam logic [15:0] DEV_BASE  = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    localparam logic [15:0] MCR_RESET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SRAM_WAIT,
        DONE
    } memState_e;

    // The whole top page from FE00 up belongs to devices, mapped or not.
    function automatic logic isDevAddr(input logic [15:0] addr);
        return addr >= DEV_BASE;
    endfunction

endpackage

// File: rtl/lc3_dev_regs.sv
// Memory-mapped keyboard, display and machine-control registers for the LC-3,
// written and read through a one-cycle access strobe with a combinational read mux.
module lc3_dev_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        devStrobe,
    input  logic [15:0] devAddr,
    input  logic        devWe,
    input  logic [15:0] devWdata,
    output logic [15:0] devRdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        mcr_run
);

    logic        kbdReady;
    logic [7:0]  kbdChar;
    logic [15:0] mcr;
    logic        wrDdr;
    logic        wrMcr;
    logic        rdKbdr;

    assign wrDdr  = devStrobe &&  devWe && (devAddr == DDR_ADDR);
    assign wrMcr  = devStrobe &&  devWe && (devAddr == MCR_ADDR);
    assign rdKbdr = devStrobe && !devWe && (devAddr == KBDR_ADDR);

    // A new keystroke beats a simultaneous KBDR read, so the fresh character is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kbdReady   <= 1'b0;
            kbdChar    <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            mcr        <= MCR_RESET;
        end else begin
            if (kbd_valid) begin
                kbdReady <= 1'b1;
                kbdChar  <= kbd_data;
            end else if (rdKbdr) begin
                kbdReady <= 1'b0;
            end

            if (wrDdr) begin
                disp_data  <= devWdata[7:0];
                disp_valid <= 1'b1;
            end else if (disp_ready) begin
                disp_valid <= 1'b0;
            end

            if (wrMcr) begin
                mcr <= devWdata;
            end
        end
    end

    always_comb begin
        devRdata = '0;
        case (devAddr)
            KBSR_ADDR: devRdata = {kbdReady, 15'b0};
            KBDR_ADDR: devRdata = {8'b0, kbdChar};
            DSR_ADDR:  devRdata = {!disp_valid, 15'b0};
            MCR_ADDR:  devRdata = mcr;
            default:   devRdata = '0;
        endcase
    end

    assign mcr_run = mcr[15];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access unit: owns MAR/MDR, runs SRAM or device accesses and returns R.
// Define LC3_MEM_TIMEOUT_EN to add the SRAM wait counter, timeout path and bus_err.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          WAIT_MAX = 15,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mem_en,
    input  logic        mem_w,
    output logic [15:0] mar_out,
    output logic [15:0] mdr_out,
    output logic        mem_ready,
    output logic        bus_err,
    output logic        sram_req,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        sram_ack,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        mcr_run
);

    memState_e   state;
    logic        accessIsDev;
    logic        devStrobe;
    logic [15:0] devRdata;
    logic        timeoutHit;

    assign accessIsDev = isDevAddr(mar_out);
    assign devStrobe   = (state == IDLE) && mem_en && accessIsDev;

    lc3_dev_regs uDevRegs (
        .clk        (clk),
        .reset      (reset),
        .devStrobe  (devStrobe),
        .devAddr    (mar_out),
        .devWe      (mem_w),
        .devWdata   (mdr_out),
        .devRdata   (devRdata),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .mcr_run    (mcr_run)
    );

`ifdef LC3_MEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    // Counts request cycles; the first SRAM_WAIT cycle is count 1.
    logic [7:0] waitCnt;

    assign timeoutHit = (waitCnt == WAIT_LIMIT);
`else
    assign timeoutHit = 1'b0;
    assign bus_err    = 1'b0;
`endif

    // SRAM address/data are latched on entry so the SRAM sees them frozen even if MAR/MDR wobble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mar_out    <= '0;
            mdr_out    <= '0;
            mem_ready  <= 1'b0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
`ifdef LC3_MEM_TIMEOUT_EN
            waitCnt    <= '0;
            bus_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (ld_mar) begin
                        mar_out <= bus_in;
                    end
                    if (ld_mdr && !mem_en) begin
                        mdr_out <= bus_in;
                    end
                    if (mem_en) begin
                        if (accessIsDev) begin
                            if (!mem_w) begin
                                mdr_out <= devRdata;
                            end
                            mem_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            sram_req   <= 1'b1;
                            sram_we    <= mem_w;
                            sram_addr  <= mar_out;
                            sram_wdata <= mdr_out;
`ifdef LC3_MEM_TIMEOUT_EN
                            waitCnt    <= 8'd1;
`endif
                            state      <= SRAM_WAIT;
                        end
                    end
                end

                SRAM_WAIT: begin
                    if (sram_ack) begin
                        if (!sram_we) begin
                            mdr_out <= sram_rdata;
                        end
                        sram_req  <= 1'b0;
                        sram_we   <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end else if (timeoutHit) begin
                        if (!sram_we) begin
                            mdr_out <= ERR_DATA;
                        end
                        sram_req  <= 1'b0;
                        sram_we   <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= DONE;
`ifdef LC3_MEM_TIMEOUT_EN
                        bus_err   <= 1'b1;
`endif
                    end else begin
`ifdef LC3_MEM_TIMEOUT_EN
                        waitCnt <= waitCnt + 8'd1;
`endif
                    end
                end

                DONE: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed testbench for lc3_mem_ctrl: a device-access vector table plus hand-written
// SRAM, timeout/stall and reset-abort sequences against a small SRAM responder.
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mem_en;
    logic        mem_w;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    logic        mem_ready;
    logic        bus_err;
    logic        sram_req;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = '0;
    logic        sram_ack = 1'b0;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        mcr_run;

    int checks = 0;
    int errors = 0;

    lc3_mem_ctrl #(.WAIT_MAX(4), .ERR_DATA(16'hDEAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_in     (bus_in),
        .ld_mar     (ld_mar),
        .ld_mdr     (ld_mdr),
        .mem_en     (mem_en),
        .mem_w      (mem_w),
        .mar_out    (mar_out),
        .mdr_out    (mdr_out),
        .mem_ready  (mem_ready),
        .bus_err    (bus_err),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ack   (sram_ack),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .mcr_run    (mcr_run)
    );

    always #5 clk = ~clk;

    // SRAM responder: acks on the ackDelay-th request cycle (0 = never) or whenever forceAck is set.
    int          reqCount  = 0;
    int          ackDelay  = 0;
    bit          forceAck  = 1'b0;
    logic [15:0] lastWaddr = '0;
    logic [15:0] lastWdata = '0;
    logic [15:0] sramModel [logic [15:0]];

    always @(negedge clk) begin
        if (sram_req) begin
            reqCount = reqCount + 1;
            if (forceAck || reqCount == ackDelay) begin
                sram_ack = 1'b1;
                if (sram_we) begin
                    sramModel[sram_addr] = sram_wdata;
                    lastWaddr = sram_addr;
                    lastWdata = sram_wdata;
                end else begin
                    sram_rdata = sramModel.exists(sram_addr) ? sramModel[sram_addr] : 16'h0000;
                end
            end else begin
                sram_ack = 1'b0;
            end
        end else begin
            reqCount = 0;
            sram_ack = 1'b0;
        end
    end

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        write;
        logic [15:0] wdata;
        int          kbdMode;
        logic [7:0]  kbdChar;
        logic        dispReadyPulse;
        logic [15:0] expMdr;
        logic        expDispValid;
        logic [7:0]  expDispData;
        logic        expMcrRun;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input string name, input logic [15:0] addr, input logic write,
                                   input logic [15:0] wdata, input int kbdMode, input logic [7:0] kbdChar,
                                   input logic dispReadyPulse, input logic [15:0] expMdr,
                                   input logic expDispValid, input logic [7:0] expDispData,
                                   input logic expMcrRun);
        vec_t v;
        v.name           = name;
        v.addr           = addr;
        v.write          = write;
        v.wdata          = wdata;
        v.kbdMode        = kbdMode;
        v.kbdChar        = kbdChar;
        v.dispReadyPulse = dispReadyPulse;
        v.expMdr         = expMdr;
        v.expDispValid   = expDispValid;
        v.expDispData    = expDispData;
        v.expMcrRun      = expMcrRun;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic loadMar(input logic [15:0] value);
        bus_in = value;
        ld_mar = 1'b1;
        @(negedge clk);
        ld_mar = 1'b0;
    endtask

    task automatic loadMdr(input logic [15:0] value);
        bus_in = value;
        ld_mdr = 1'b1;
        mem_en = 1'b0;
        @(negedge clk);
        ld_mdr = 1'b0;
    endtask

    task automatic startAccess(input logic write);
        mem_w  = write;
        ld_mdr = !write;
        mem_en = 1'b1;
    endtask

    task automatic waitReady(input int maxCycles, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            if (mem_ready) seen = 1'b1;
        end
    endtask

    task automatic endAccess();
        mem_en = 1'b0;
        mem_w  = 1'b0;
        ld_mdr = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, output int cycles, output bit seen);
        if (v.kbdMode == 1) begin
            kbd_data  = v.kbdChar;
            kbd_valid = 1'b1;
            @(negedge clk);
            kbd_valid = 1'b0;
        end
        if (v.dispReadyPulse) begin
            disp_ready = 1'b1;
            @(negedge clk);
            disp_ready = 1'b0;
        end
        loadMar(v.addr);
        if (v.write) loadMdr(v.wdata);
        startAccess(v.write);
        if (v.kbdMode == 2) begin
            kbd_data  = v.kbdChar;
            kbd_valid = 1'b1;
        end
        waitReady(4, cycles, seen);
        kbd_valid = 1'b0;
        endAccess();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int cyc2;
        bit seen;
        int readySeen;

        reset      = 1'b0;
        bus_in     = '0;
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        mem_en     = 1'b0;
        mem_w      = 1'b0;
        kbd_valid  = 1'b0;
        kbd_data   = '0;
        disp_ready = 1'b0;
        sramModel[16'h0100] = 16'hBEEF;

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset mar", mar_out, 16'h0000);
        checkOutput("reset mdr", mdr_out, 16'h0000);
        checkOutput("reset mem_ready", mem_ready, 0);
        checkOutput("reset sram_req", sram_req, 0);
        checkOutput("reset sram_we", sram_we, 0);
        checkOutput("reset sram_addr", sram_addr, 16'h0000);
        checkOutput("reset sram_wdata", sram_wdata, 16'h0000);
        checkOutput("reset bus_err", bus_err, 0);
        checkOutput("reset disp_valid", disp_valid, 0);
        checkOutput("reset disp_data", disp_data, 0);
        checkOutput("reset mcr_run", mcr_run, 1);

        // SRAM write: ack on the third request cycle, so R arrives at N+4.
        loadMar(16'h3000);
        loadMdr(16'h1234);
        checkOutput("mar load", mar_out, 16'h3000);
        checkOutput("mdr load", mdr_out, 16'h1234);
        ackDelay = 3;
        startAccess(1'b1);
        waitReady(8, cyc, seen);
        endAccess();
        checkOutput("sram write ready", seen, 1);
        checkOutput("sram write latency", 16'(cyc), 16'd4);
        checkOutput("sram write wdata", lastWdata, 16'h1234);
        checkOutput("sram write addr", lastWaddr, 16'h3000);
        checkOutput("sram write sram_wdata", sram_wdata, 16'h1234);
        checkOutput("sram write req dropped", sram_req, 0);
        checkOutput("sram write ready one cycle", mem_ready, 0);

        // SRAM read at minimum latency.
        loadMdr(16'h0000);
        ackDelay = 1;
        startAccess(1'b0);
        waitReady(8, cyc, seen);
        endAccess();
        checkOutput("sram read ready", seen, 1);
        checkOutput("sram read latency", 16'(cyc), 16'd2);
        checkOutput("sram read mdr", mdr_out, 16'h1234);

        // ld_mar while waiting on SRAM must not disturb MAR.
        loadMdr(16'h0000);
        ackDelay = 3;
        startAccess(1'b0);
        @(negedge clk);
        bus_in = 16'hAAAA;
        ld_mar = 1'b1;
        waitReady(8, cyc, seen);
        ld_mar = 1'b0;
        endAccess();
        checkOutput("busy ld_mar ready", seen, 1);
        checkOutput("busy ld_mar latency", 16'(cyc + 1), 16'd4);
        checkOutput("busy ld_mar mar", mar_out, 16'h3000);
        checkOutput("busy ld_mar mdr", mdr_out, 16'h1234);

        vecs.push_back(mkVec("kbsr after key", 16'hFE00, 0, 16'h0000, 1, 8'h41, 0, 16'h8000, 0, 8'h00, 1));
        vecs.push_back(mkVec("kbdr read",      16'hFE02, 0, 16'h0000, 0, 8'h00, 0, 16'h0041, 0, 8'h00, 1));
        vecs.push_back(mkVec("kbsr cleared",   16'hFE00, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1));
        vecs.push_back(mkVec("kbdr collide",   16'hFE02, 0, 16'h0000, 2, 8'h43, 0, 16'h0041, 0, 8'h00, 1));
        vecs.push_back(mkVec("kbsr set wins",  16'hFE00, 0, 16'h0000, 0, 8'h00, 0, 16'h8000, 0, 8'h00, 1));
        vecs.push_back(mkVec("kbdr new char",  16'hFE02, 0, 16'h0000, 0, 8'h00, 0, 16'h0043, 0, 8'h00, 1));
        vecs.push_back(mkVec("kbsr clear 2",   16'hFE00, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1));
        vecs.push_back(mkVec("ddr write",      16'hFE06, 1, 16'h0058, 0, 8'h00, 0, 16'h0058, 1, 8'h58, 1));
        vecs.push_back(mkVec("dsr busy",       16'hFE04, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 8'h58, 1));
        vecs.push_back(mkVec("dsr ready",      16'hFE04, 0, 16'h0000, 0, 8'h00, 1, 16'h8000, 0, 8'h58, 1));
        vecs.push_back(mkVec("unmapped read",  16'hFE10, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h58, 1));
        vecs.push_back(mkVec("kbsr write",     16'hFE00, 1, 16'h1234, 0, 8'h00, 0, 16'h1234, 0, 8'h58, 1));
        vecs.push_back(mkVec("kbsr unchanged", 16'hFE00, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h58, 1));
        vecs.push_back(mkVec("mcr write 0",    16'hFFFE, 1, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h58, 0));
        vecs.push_back(mkVec("mcr read 0",     16'hFFFE, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h58, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], cyc, seen);
            checkOutput({vecs[i].name, " ready"}, seen, 1);
            checkOutput({vecs[i].name, " latency"}, 16'(cyc), 16'd1);
            checkOutput({vecs[i].name, " mdr"}, mdr_out, vecs[i].expMdr);
            checkOutput({vecs[i].name, " disp_valid"}, disp_valid, vecs[i].expDispValid);
            checkOutput({vecs[i].name, " disp_data"}, disp_data, vecs[i].expDispData);
            checkOutput({vecs[i].name, " mcr_run"}, mcr_run, vecs[i].expMcrRun);
        end

        // SRAM read that never gets an ack.
        loadMar(16'h0100);
        ackDelay = 0;
        startAccess(1'b0);
`ifdef LC3_MEM_TIMEOUT_EN
        waitReady(10, cyc, seen);
        endAccess();
        checkOutput("timeout ready", seen, 1);
        checkOutput("timeout latency", 16'(cyc), 16'd5);
        checkOutput("timeout mdr", mdr_out, 16'hDEAD);
        checkOutput("timeout bus_err", bus_err, 1);
        checkOutput("timeout req dropped", sram_req, 0);
`else
        waitReady(8, cyc, seen);
        checkOutput("stall no ready", seen, 0);
        checkOutput("stall req held", sram_req, 1);
        checkOutput("stall bus_err", bus_err, 0);
        forceAck = 1'b1;
        waitReady(4, cyc2, seen);
        endAccess();
        forceAck = 1'b0;
        checkOutput("stall ready after ack", seen, 1);
        checkOutput("stall mdr", mdr_out, 16'hBEEF);
`endif

        // Reset in the middle of an SRAM wait aborts it without R.
        loadMar(16'h0200);
        ackDelay = 0;
        startAccess(1'b0);
        repeat (2) @(negedge clk);
        checkOutput("abort req before reset", sram_req, 1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort req dropped", sram_req, 0);
        checkOutput("abort no ready", mem_ready, 0);
        reset  = 1'b1;
        mem_en = 1'b0;
        ld_mdr = 1'b0;
        readySeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_ready || sram_req) readySeen++;
        end
        checkOutput("abort stays quiet", 16'(readySeen), 16'd0);
        checkOutput("abort mar reset", mar_out, 16'h0000);
        checkOutput("post reset mcr_run", mcr_run, 1);
        checkOutput("post reset bus_err", bus_err, 0);
        checkOutput("post reset disp_data", disp_data, 0);

        // The FSM is back in IDLE: a device read completes in one cycle and shows MCR reset.
        loadMar(16'hFFFE);
        startAccess(1'b0);
        waitReady(4, cyc, seen);
        endAccess();
        checkOutput("mcr read after reset ready", seen, 1);
        checkOutput("mcr read after reset latency", 16'(cyc), 16'd1);
        checkOutput("mcr read after reset", mdr_out, 16'h8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
